// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin scan used by the AXI-stream arbiter.
// Supports up to MAX_REQ requesters; the scan wraps modulo the live requester count.
package axis_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned IDX_W   = 5;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Lowest index k >= ptr with req[k] set, wrapping modulo n_req.
  function automatic rr_pick_t rr_next_idx(input logic [MAX_REQ-1:0] req,
                                           input logic [IDX_W-1:0]   ptr,
                                           input int unsigned        n_req);
    rr_pick_t    pick;
    int unsigned k;
    pick = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      k = 32'(ptr) + i;
      if (k >= n_req) k = k - n_req;
      if (i < n_req && !pick.found && req[k[IDX_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = k[IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.
// N_REQ must be in 2..MAX_REQ.
module rr_priority_picker
  import axis_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IdxW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic [IdxW-1:0]  idx,
  output logic             found
);

  logic [MAX_REQ-1:0] req_ext;
  rr_pick_t           pick;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    pick                 = rr_next_idx(req_ext, IDX_W'(ptr), N_REQ);
    idx                  = IdxW'(pick.idx);
    found                = pick.found;
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter sharing one AXI-stream slave among N_REQ masters.
// Only the grant is registered; the granted channel is muxed combinationally.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  localparam int unsigned IdxW = $clog2(N_REQ),
  localparam int unsigned CntW = $clog2(MAX_BURST + 1)
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic [N_REQ-1:0]            s_tvalid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_tdata_i,
  output logic [N_REQ-1:0]            s_tready_o,
  output logic                        m_tvalid_o,
  output logic [DATA_WIDTH-1:0]       m_tdata_o,
  input  logic                        m_tready_i,
  output logic                        grant_valid_o,
  output logic [IdxW-1:0]             grant_idx_o,
  output logic [CntW-1:0]             beat_cnt_o
);

  arb_state_t      state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] pick_idx;
  logic            pick_found;
  logic [IdxW-1:0] next_ptr;
  logic            last_beat;
  logic            hs;

  rr_priority_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req   (s_tvalid_i),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Explicit wrap keeps non-power-of-2 requester counts legal.
  assign next_ptr  = (grant_q == IdxW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign last_beat = (cnt_q == CntW'(MAX_BURST - 1));
  assign hs        = m_tvalid_o & m_tready_i;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A dropped tvalid means no beat is pending, so releasing is AXI-safe.
        if (!s_tvalid_i[grant_q]) begin
          state_d = IDLE;
          ptr_d   = next_ptr;
        end else if (hs) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = IDLE;
            ptr_d   = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_tvalid_o    = 1'b0;
    m_tdata_o     = '0;
    s_tready_o    = '0;
    grant_valid_o = (state_q == GRANT);
    grant_idx_o   = grant_q;
    beat_cnt_o    = cnt_q;
    if (state_q == GRANT) begin
      m_tvalid_o          = s_tvalid_i[grant_q];
      m_tdata_o           = s_tdata_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
      s_tready_o[grant_q] = m_tready_i;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench: a 4-way MAX_BURST=4 instance and a 3-way MAX_BURST=1 instance.
module tb_axis_rr_arbiter;

  typedef struct packed {
    logic [1:0]  idx;
    logic [2:0]  cnt;
    logic [31:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N_REQ=4, MAX_BURST=4
  logic [3:0]   a_s_tvalid;
  logic [127:0] a_s_tdata;
  logic [3:0]   a_s_tready;
  logic         a_m_tvalid;
  logic [31:0]  a_m_tdata;
  logic         m_tready;
  logic         a_grant_valid;
  logic [1:0]   a_grant_idx;
  logic [2:0]   a_beat_cnt;

  // Instance B: N_REQ=3, MAX_BURST=1
  logic [2:0]   b_s_tvalid;
  logic [47:0]  b_s_tdata;
  logic [2:0]   b_s_tready;
  logic         b_m_tvalid;
  logic [15:0]  b_m_tdata;
  logic         b_m_tready;
  logic         b_grant_valid;
  logic [1:0]   b_grant_idx;
  logic [0:0]   b_beat_cnt;

  axis_rr_arbiter #(
    .N_REQ      (4),
    .DATA_WIDTH (32),
    .MAX_BURST  (4)
  ) u_dut_a (
    .clock_i       (clk),
    .reset_i       (rst_n),
    .s_tvalid_i    (a_s_tvalid),
    .s_tdata_i     (a_s_tdata),
    .s_tready_o    (a_s_tready),
    .m_tvalid_o    (a_m_tvalid),
    .m_tdata_o     (a_m_tdata),
    .m_tready_i    (m_tready),
    .grant_valid_o (a_grant_valid),
    .grant_idx_o   (a_grant_idx),
    .beat_cnt_o    (a_beat_cnt)
  );

  axis_rr_arbiter #(
    .N_REQ      (3),
    .DATA_WIDTH (16),
    .MAX_BURST  (1)
  ) u_dut_b (
    .clock_i       (clk),
    .reset_i       (rst_n),
    .s_tvalid_i    (b_s_tvalid),
    .s_tdata_i     (b_s_tdata),
    .s_tready_o    (b_s_tready),
    .m_tvalid_o    (b_m_tvalid),
    .m_tdata_o     (b_m_tdata),
    .m_tready_i    (b_m_tready),
    .grant_valid_o (b_grant_valid),
    .grant_idx_o   (b_grant_idx),
    .beat_cnt_o    (b_beat_cnt)
  );

  logic [31:0] src_q[4][$];
  beat_t       sb[$];
  logic [1:0]  b_sb[$];
  int          n_total = 0;
  int          n_bad = 0;
  logic        bp_on = 1'b0;
  int          gap = 0;

  function automatic logic [31:0] tag(int k, int t, int b);
    return {8'(k), 8'(t), 16'(b)};
  endfunction

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic src_push(input int k, input logic [31:0] d);
    src_q[k].push_back(d);
  endtask

  task automatic exp_push(input int k, input int c, input logic [31:0] d);
    sb.push_back(beat_t'{idx: 2'(k), cnt: 3'(c), data: d});
  endtask

  task automatic drive_src();
    for (int k = 0; k < 4; k++) begin
      a_s_tvalid[k]         = (src_q[k].size() != 0);
      a_s_tdata[k*32 +: 32] = (src_q[k].size() != 0) ? src_q[k][0] : 32'h0;
    end
  endtask

  // One clock: check outputs at the falling edge, then update sources after the rising edge.
  task automatic step();
    logic [3:0] hs;
    beat_t      e;
    logic [1:0] be;
    @(negedge clk);
    hs = a_s_tvalid & a_s_tready;
    if (!a_grant_valid) begin
      check_eq("idle_m_tvalid", 64'(a_m_tvalid), 64'(0));
      check_eq("idle_s_tready", 64'(a_s_tready), 64'(0));
    end
    if (a_m_tvalid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_beat", 64'(a_m_tvalid), 64'(0));
      end else begin
        e = sb[0];
        check_eq("s_tready_onehot", 64'(a_s_tready), 64'(m_tready ? (4'b1 << e.idx) : 4'b0));
        if (m_tready) begin
          void'(sb.pop_front());
          check_eq("beat_idx", 64'(a_grant_idx), 64'(e.idx));
          check_eq("beat_cnt", 64'(a_beat_cnt), 64'(e.cnt));
          check_eq("beat_data", 64'(a_m_tdata), 64'(e.data));
        end
      end
    end
    if (b_m_tvalid) begin
      if (b_sb.size() == 0) begin
        check_eq("b_unexpected_beat", 64'(b_m_tvalid), 64'(0));
      end else begin
        be = b_sb.pop_front();
        check_eq("b_idx", 64'(b_grant_idx), 64'(be));
        check_eq("b_data", 64'(b_m_tdata), 64'(16'hB000 + 16'(be)));
        check_eq("b_s_tready", 64'(b_s_tready), 64'(3'b1 << be));
        check_eq("b_beat_cnt", 64'(b_beat_cnt), 64'(0));
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (hs[k]) void'(src_q[k].pop_front());
    end
    if (bp_on) begin
      if (gap > 0) begin
        m_tready = 1'b0;
        gap--;
      end else begin
        m_tready = 1'b1;
        gap = $urandom_range(0, 10);
      end
    end else begin
      m_tready = 1'b1;
    end
    drive_src();
  endtask

  task automatic drain(input string name, input int max_cycles);
    int i;
    i = 0;
    while (sb.size() != 0 && i < max_cycles) begin
      step();
      i++;
    end
    check_eq(name, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    m_tready   = 1'b1;
    b_m_tready = 1'b1;
    a_s_tvalid = '0;
    a_s_tdata  = '0;
    b_s_tvalid = '0;
    b_s_tdata  = {16'hB002, 16'hB001, 16'hB000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_grant_valid", 64'(a_grant_valid), 64'(0));
    check_eq("rst_grant_idx", 64'(a_grant_idx), 64'(0));
    check_eq("rst_beat_cnt", 64'(a_beat_cnt), 64'(0));
    check_eq("rst_m_tvalid", 64'(a_m_tvalid), 64'(0));
    check_eq("rst_s_tready", 64'(a_s_tready), 64'(0));
    check_eq("rst_m_tdata", 64'(a_m_tdata), 64'(0));
    check_eq("rst_b_grant_valid", 64'(b_grant_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // B: MAX_BURST=1 alternation 0,1,0,1, each grant = bubble + one beat
    for (int i = 0; i < 4; i++) b_sb.push_back(2'(i % 2));
    b_s_tvalid = 3'b011;
    repeat (7) step();
    check_eq("b_alt_7", 64'(b_sb.size()), 64'(1));
    step();
    check_eq("b_alt_8", 64'(b_sb.size()), 64'(0));
    b_s_tvalid = 3'b000;

    // B: pointer now 2, requests on 0 and 2 -> 2 then wrap to 0
    b_sb.push_back(2'd2);
    b_sb.push_back(2'd0);
    b_s_tvalid = 3'b101;
    repeat (4) step();
    check_eq("b_wrap", 64'(b_sb.size()), 64'(0));
    b_s_tvalid = 3'b000;
    step();

    // A: all four valid, grant order 0,1,2,3,0 with 4 beats each and one bubble
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 4; b++) src_push(k, tag(k, 1, b));
    for (int b = 4; b < 8; b++) src_push(0, tag(0, 1, b));
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 4; b++) exp_push(k, b, tag(k, 1, b));
    for (int b = 4; b < 8; b++) exp_push(0, b - 4, tag(0, 1, b));
    drive_src();
    repeat (24) step();
    check_eq("rr4_after_24", 64'(sb.size()), 64'(1));
    step();
    check_eq("rr4_after_25", 64'(sb.size()), 64'(0));
    check_eq("rr4_idle_after", 64'(a_grant_valid), 64'(0));

    // A: single requester 2, 5 beats -> split 4 + 1 with re-grant of 2
    for (int b = 0; b < 5; b++) begin
      src_push(2, tag(2, 2, b));
      exp_push(2, b % 4, tag(2, 2, b));
    end
    drive_src();
    check_eq("t1_pre_grant", 64'(a_grant_valid), 64'(0));
    step();
    check_eq("t1_grant_valid", 64'(a_grant_valid), 64'(1));
    check_eq("t1_grant_idx", 64'(a_grant_idx), 64'(2));
    check_eq("t1_beat_cnt0", 64'(a_beat_cnt), 64'(0));
    check_eq("t1_m_tvalid", 64'(a_m_tvalid), 64'(1));
    drain("t1_drain", 20);
    step();
    check_eq("t1_released", 64'(a_grant_valid), 64'(0));

    // A: pointer now 3, requests on 1 and 3 -> 3 first, then 1
    for (int b = 0; b < 2; b++) begin
      src_push(1, tag(1, 3, b));
      src_push(3, tag(3, 3, b));
    end
    for (int b = 0; b < 2; b++) exp_push(3, b, tag(3, 3, b));
    for (int b = 0; b < 2; b++) exp_push(1, b, tag(1, 3, b));
    drive_src();
    drain("wrap_drain", 30);
    step();

    // A: back-pressure on requester 1; requester 0 arrives mid-burst and must wait
    bp_on = 1'b1;
    gap   = 0;
    for (int b = 0; b < 4; b++) begin
      src_push(1, tag(1, 4, b));
      exp_push(1, b, tag(1, 4, b));
    end
    drive_src();
    repeat (3) step();
    for (int b = 0; b < 2; b++) begin
      src_push(0, tag(0, 4, b));
      exp_push(0, b, tag(0, 4, b));
    end
    drive_src();
    drain("bp_drain", 300);
    bp_on = 1'b0;
    repeat (2) step();

    // A: reset during beat 2 of 4 from requester 2; restart grants requester 0 first
    for (int b = 0; b < 4; b++) begin
      src_push(2, tag(2, 5, b));
      src_push(0, tag(0, 5, b));
    end
    for (int b = 0; b < 2; b++) exp_push(2, b, tag(2, 5, b));
    drive_src();
    drain("rst_pre_drain", 20);
    check_eq("rst_mid_tvalid", 64'(a_m_tvalid), 64'(1));
    rst_n = 1'b0;
    #1;
    check_eq("rstm_m_tvalid", 64'(a_m_tvalid), 64'(0));
    check_eq("rstm_s_tready", 64'(a_s_tready), 64'(0));
    check_eq("rstm_m_tdata", 64'(a_m_tdata), 64'(0));
    check_eq("rstm_grant_valid", 64'(a_grant_valid), 64'(0));
    check_eq("rstm_grant_idx", 64'(a_grant_idx), 64'(0));
    check_eq("rstm_beat_cnt", 64'(a_beat_cnt), 64'(0));
    for (int b = 0; b < 4; b++) exp_push(0, b, tag(0, 5, b));
    for (int b = 2; b < 4; b++) exp_push(2, b - 2, tag(2, 5, b));
    @(negedge clk);
    rst_n = 1'b1;
    drain("rst_post_drain", 40);
    step();
    check_eq("rst_post_idle", 64'(a_grant_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
